sum_serial_nb: RTL and testbench

//  Bit-serial N-bit adder built around the 1-bit full adder (sum1b), which it

---
 rtl/sum_serial_nb.sv | 147 ++++++++++++++
 tb/tb_sum_serial_nb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_serial_nb.sv
// sum_serial_nb: bit-serial N-bit adder.
// Two operands and a carry-in are latched on an accepted start and then fed
// LSB first, one bit pair per clock, through a single 1-bit full adder
// (sum1b). The carry is held in a register between cycles. Each sum bit is
// shifted into a result register from the MSB end. S/Cout are loaded only
// when the last bit has been summed, and then held until the next completion.

// sum1b: 1-bit full adder, the arithmetic core of the serial adder.
module sum1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module sum_serial_nb #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Cout
);

    // Counter needs at least one bit even when N == 1.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  res_sr;
    logic          carry;
    logic [CW-1:0] cnt;

    logic          fa_s;
    logic          fa_co;
    logic [N:0]    res_wide;
    logic [N-1:0]  res_next;
    logic          accept;
    logic          last_bit;

    sum1b u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // The new sum bit enters at the MSB while the rest moves one place right.
    // Building it through an N+1 wide vector keeps the N == 1 case legal.
    assign res_wide = {fa_s, res_sr};
    assign res_next = res_wide[N:1];

    // A start is only honoured when no addition is in flight.
    assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_bit = (state == ST_RUN) && (cnt == LAST_CNT);

    // Next-state decode for the IDLE / RUN / DONE sequence.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_RUN);
            done  <= (state_next == ST_DONE);
        end
    end

    // Serial datapath: load on accept, otherwise shift one bit per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr   <= A;
            b_sr   <= B;
            res_sr <= '0;
            carry  <= Ci;
            cnt    <= '0;
        end else if (state == ST_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            carry  <= fa_co;
            cnt    <= cnt + CW'(1);
        end
    end

    // Result outputs change only when the final bit has been summed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            Cout <= 1'b0;
        end else if (last_bit) begin
            S    <= res_next;
            Cout <= fa_co;
        end
    end

endmodule

// File: tb/tb_sum_serial_nb.sv
// tb_sum_serial_nb: checks an 8-bit and a 1-bit instance of sum_serial_nb
// against a transaction-level model of the adder (A + B + Ci, result due
// N edges after the accepting edge), plus a set of hand-computed results.

module tb_sum_serial_nb;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8     = '0;
    logic [7:0] b8     = '0;
    logic       ci8    = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] s8;
    logic       cout8;

    logic start1 = 1'b0;
    logic a1     = 1'b0;
    logic b1     = 1'b0;
    logic ci1    = 1'b0;
    logic busy1;
    logic done1;
    logic s1;
    logic cout1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state, index 0 = N=8 instance, index 1 = N=1 instance.
    int          width   [2] = '{8, 1};
    bit          active  [2] = '{0, 0};
    longint      fin_edge[2] = '{0, 0};
    logic [8:0]  pend    [2] = '{9'd0, 9'd0};
    logic        exp_busy[2] = '{1'b0, 1'b0};
    logic        exp_done[2] = '{1'b0, 1'b0};
    logic [7:0]  exp_s   [2] = '{8'd0, 8'd0};
    logic        exp_c   [2] = '{1'b0, 1'b0};
    longint      edge_no     = 0;

    // {Cout,S} of a full adder indexed by {a,b,ci}.
    logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    sum_serial_nb #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .Ci    (ci8),
        .busy  (busy8),
        .done  (done8),
        .S     (s8),
        .Cout  (cout8)
    );

    sum_serial_nb #(.N(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .A     (a1),
        .B     (b1),
        .Ci    (ci1),
        .busy  (busy1),
        .done  (done1),
        .S     (s1),
        .Cout  (cout1)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted start records A+B+Ci and the edge at
    // which the result must appear; a start while an op is pending is dropped.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                active[i]   = 1'b0;
                exp_busy[i] = 1'b0;
                exp_done[i] = 1'b0;
                exp_s[i]    = '0;
                exp_c[i]    = 1'b0;
            end
        end else begin
            edge_no++;
            for (int i = 0; i < 2; i++) begin
                logic       st;
                logic [8:0] sum;
                st  = (i == 0) ? start8 : start1;
                sum = (i == 0) ? (9'(a8) + 9'(b8) + 9'(ci8))
                               : (9'(a1) + 9'(b1) + 9'(ci1));
                exp_done[i] = 1'b0;
                if (active[i] && edge_no == fin_edge[i]) begin
                    exp_s[i]    = 8'(pend[i] & ((9'd1 << width[i]) - 9'd1));
                    exp_c[i]    = pend[i][width[i]];
                    exp_done[i] = 1'b1;
                    active[i]   = 1'b0;
                end else if (!active[i] && st) begin
                    active[i]   = 1'b1;
                    fin_edge[i] = edge_no + longint'(width[i]);
                    pend[i]     = sum;
                end
                exp_busy[i] = active[i];
            end
        end
    end

    // Every cycle, all outputs of both instances must match the model.
    always @(negedge clk) begin
        check_output("busy8", 16'(busy8), 16'(exp_busy[0]));
        check_output("done8", 16'(done8), 16'(exp_done[0]));
        check_output("s8",    16'(s8),    16'(exp_s[0]));
        check_output("cout8", 16'(cout8), 16'(exp_c[0]));
        check_output("busy1", 16'(busy1), 16'(exp_busy[1]));
        check_output("done1", 16'(done1), 16'(exp_done[1]));
        check_output("s1",    16'(s1),    16'(exp_s[1]));
        check_output("cout1", 16'(cout1), 16'(exp_c[1]));
    end

    task automatic apply_stimulus(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clk);
        if (sel) begin
            a1 = a[0]; b1 = b[0]; ci1 = ci; start1 = 1'b1;
        end else begin
            a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
        end
        @(negedge clk);
        start1 = 1'b0;
        start8 = 1'b0;
    endtask

    // Bounded wait for a done pulse; counts cycles waited and busy cycles seen.
    task automatic wait_done(input bit sel, output int waited, output int busy_seen);
        waited    = 0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (sel ? done1 : done8) break;
            if (sel ? busy1 : busy8) busy_seen++;
            @(negedge clk);
            waited++;
        end
        if (!(sel ? done1 : done8)) begin
            check_output("done_timeout", 16'd0, 16'd1);
        end
    endtask

    initial begin
        int w;
        int bs;

        repeat (3) @(negedge clk);
        check_output("reset_busy", 16'(busy8), 16'd0);
        check_output("reset_s",    16'(s8),    16'd0);
        rst_n = 1'b1;

        // Basic addition with busy length and latency.
        apply_stimulus(0, 8'h5A, 8'h3C, 1'b0);
        wait_done(0, w, bs);
        check_output("t1_s",       16'(s8),       16'h96);
        check_output("t1_cout",    16'(cout8),    16'h0);
        check_output("t1_busy",    16'(bs),       16'd8);
        check_output("t1_latency", 16'(w),        16'd8);
        check_output("t1_model_s", 16'(exp_s[0]), 16'h96);

        // Carry-out boundary cases.
        apply_stimulus(0, 8'hFF, 8'h01, 1'b0);
        wait_done(0, w, bs);
        check_output("t2a_s",    16'(s8),    16'h00);
        check_output("t2a_cout", 16'(cout8), 16'h1);
        apply_stimulus(0, 8'hFF, 8'hFF, 1'b1);
        wait_done(0, w, bs);
        check_output("t2b_s",       16'(s8),       16'hFF);
        check_output("t2b_cout",    16'(cout8),    16'h1);
        check_output("t2b_model_c", 16'(exp_c[0]), 16'h1);

        // Start during RUN must be ignored.
        apply_stimulus(0, 8'h0F, 8'h01, 1'b0);
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done(0, w, bs);
        check_output("t3_s",    16'(s8),    16'h10);
        check_output("t3_cout", 16'(cout8), 16'h0);
        @(negedge clk);
        check_output("t3_single_done", 16'(done8), 16'h0);

        // Asynchronous reset in the middle of an addition.
        apply_stimulus(0, 8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("t4_busy", 16'(busy8), 16'h0);
        check_output("t4_s",    16'(s8),    16'h0);
        check_output("t4_cout", 16'(cout8), 16'h0);
        check_output("t4_done", 16'(done8), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(0, 8'h80, 8'h80, 1'b0);
        wait_done(0, w, bs);
        check_output("t4r_s",    16'(s8),    16'h00);
        check_output("t4r_cout", 16'(cout8), 16'h1);

        // Back-to-back: start held through DONE; done pulses N+1 apart.
        @(negedge clk);
        a8 = 8'h21; b8 = 8'h43; ci8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        wait_done(0, w, bs);
        check_output("t5_s1", 16'(s8), 16'h65);
        @(negedge clk);
        wait_done(0, w, bs);
        start8 = 1'b0;
        check_output("t5_spacing", 16'(w + 1), 16'd9);
        check_output("t5_s2",      16'(s8),    16'h65);
        repeat (12) @(negedge clk);

        // N=1: every {A,B,Ci} combination against the full adder truth table.
        for (int v = 0; v < 8; v++) begin
            logic [2:0] bits;
            bits = 3'(v);
            apply_stimulus(1, {7'd0, bits[2]}, {7'd0, bits[1]}, bits[0]);
            wait_done(1, w, bs);
            check_output("t6_sum1b", 16'({cout1, s1}), 16'(tt[v]));
        end

        // Randomised traffic on both instances, checked by the model each cycle.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            start8 = ($urandom_range(0, 3) == 0);
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            ci8    = 1'($urandom_range(0, 1));
            start1 = ($urandom_range(0, 2) == 0);
            a1     = 1'($urandom_range(0, 1));
            b1     = 1'($urandom_range(0, 1));
            ci1    = 1'($urandom_range(0, 1));
        end
        start8 = 1'b0;
        start1 = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
